// File: rtl/miriscv_gpr_wb_arbiter.sv
// miriscv_gpr_wb_arbiter
// Shares the single GPR write port between EX (ALU/CSR results) and LSU
// (load data). The granted write is registered for one cycle before it
// reaches the GPR write port. Combinational hazard flags tell decode when
// rs1/rs2 has a write that is requested, or registered and about to land.
//
// Build option MIRISCV_WB_RR_EN: when defined, round-robin arbitration
// replaces fixed LSU priority plus the EX starvation counter. In that case
// ex_starved_o is tied low and STARVE_LIMIT is ignored.
//
// Handshake: valid/ready. A transfer happens in any cycle where valid and
// ready are both high. Ready is combinational from the current valids and
// the arbitration state, and at most one ready is high per cycle. A
// requester holds addr/data stable while valid is high and ready is low.
// Both readies are forced low while rst_i is high.
module miriscv_gpr_wb_arbiter #(
  parameter int XLEN           = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic [GPR_ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [XLEN-1:0]           ex_data_i,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]           lsu_data_i,
  output logic                      gpr_wr_en_o,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr_o,
  output logic [XLEN-1:0]           gpr_wr_data_o,
  input  logic [GPR_ADDR_WIDTH-1:0] hz1_addr_i,
  input  logic [GPR_ADDR_WIDTH-1:0] hz2_addr_i,
  output logic                      hz1_o,
  output logic                      hz2_o,
  output logic                      ex_starved_o
);

  logic                      ex_xfer;
  logic                      lsu_xfer;
  logic [GPR_ADDR_WIDTH-1:0] grant_addr;
  logic [XLEN-1:0]           grant_data;
  logic                      wr_en_q;

  assign ex_xfer  = ex_valid_i && ex_ready_o;
  assign lsu_xfer = lsu_valid_i && lsu_ready_o;

`ifdef MIRISCV_WB_RR_EN
  // last_grant: 0 = EX was granted last, 1 = LSU was granted last.
  logic last_grant;

  // Round-robin grant: on a conflict the requester not granted last wins.
  always_comb begin
    ex_ready_o  = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst_i) begin
      if (ex_valid_i && lsu_valid_i) begin
        ex_ready_o  = last_grant;
        lsu_ready_o = !last_grant;
      end else begin
        ex_ready_o  = ex_valid_i;
        lsu_ready_o = lsu_valid_i;
      end
    end
  end

  // Remember which requester won the most recent transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 1'b0;
    end else if (ex_xfer) begin
      last_grant <= 1'b0;
    end else if (lsu_xfer) begin
      last_grant <= 1'b1;
    end
  end

  assign ex_starved_o = 1'b0;
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Consecutive cycles EX has been held off; saturates at STARVE_MAX.
  logic [3:0] starv_cnt;
  logic       starved;

  assign starved = (starv_cnt == STARVE_MAX);

  // Fixed LSU priority, flipped to EX once EX has waited long enough.
  always_comb begin
    ex_ready_o  = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst_i) begin
      if (starved) begin
        ex_ready_o  = ex_valid_i;
        lsu_ready_o = lsu_valid_i && !ex_valid_i;
      end else begin
        lsu_ready_o = lsu_valid_i;
        ex_ready_o  = ex_valid_i && !lsu_valid_i;
      end
    end
  end

  // Count EX-blocked cycles; any EX transfer or idle EX restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starv_cnt <= 4'd0;
    end else if (!ex_valid_i || ex_ready_o) begin
      starv_cnt <= 4'd0;
    end else if (!starved) begin
      starv_cnt <= starv_cnt + 4'd1;
    end
  end

  assign ex_starved_o = starved && !rst_i;
`endif

  // Select the address/data of whichever requester transfers this cycle.
  always_comb begin
    grant_addr = lsu_addr_i;
    grant_data = lsu_data_i;
    if (ex_xfer) begin
      grant_addr = ex_addr_i;
      grant_data = ex_data_i;
    end
  end

  // Output stage: register the granted write; x0 writes are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q       <= 1'b0;
      gpr_wr_addr_o <= '0;
      gpr_wr_data_o <= '0;
    end else begin
      wr_en_q <= (ex_xfer || lsu_xfer) && (grant_addr != '0);
      if (ex_xfer || lsu_xfer) begin
        gpr_wr_addr_o <= grant_addr;
        gpr_wr_data_o <= grant_data;
      end
    end
  end

  // A registered write still in flight when reset arrives never reaches the GPR.
  assign gpr_wr_en_o = wr_en_q && !rst_i;

  // Hazard flags: requested or registered writes to a nonzero source register.
  assign hz1_o = !rst_i && (hz1_addr_i != '0) &&
                 ((ex_valid_i  && (ex_addr_i     == hz1_addr_i)) ||
                  (lsu_valid_i && (lsu_addr_i    == hz1_addr_i)) ||
                  (gpr_wr_en_o && (gpr_wr_addr_o == hz1_addr_i)));

  assign hz2_o = !rst_i && (hz2_addr_i != '0) &&
                 ((ex_valid_i  && (ex_addr_i     == hz2_addr_i)) ||
                  (lsu_valid_i && (lsu_addr_i    == hz2_addr_i)) ||
                  (gpr_wr_en_o && (gpr_wr_addr_o == hz2_addr_i)));

endmodule

// File: tb/tb_miriscv_gpr_wb_arbiter.sv
// Testbench for miriscv_gpr_wb_arbiter (default build: fixed priority plus
// starvation counter). Directed vector table for the named scenarios, then
// randomized traffic checked against a behavioural reference model and a
// write-order scoreboard.
module tb_miriscv_gpr_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int SL   = 4;

  logic            clk;
  logic            rst;
  logic            ex_valid, ex_ready;
  logic [AW-1:0]   ex_addr;
  logic [XLEN-1:0] ex_data;
  logic            lsu_valid, lsu_ready;
  logic [AW-1:0]   lsu_addr;
  logic [XLEN-1:0] lsu_data;
  logic            gpr_wr_en;
  logic [AW-1:0]   gpr_wr_addr;
  logic [XLEN-1:0] gpr_wr_data;
  logic [AW-1:0]   hz1_addr, hz2_addr;
  logic            hz1, hz2;
  logic            ex_starved;

  miriscv_gpr_wb_arbiter #(
    .XLEN(XLEN),
    .GPR_ADDR_WIDTH(AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ex_valid_i(ex_valid),
    .ex_ready_o(ex_ready),
    .ex_addr_i(ex_addr),
    .ex_data_i(ex_data),
    .lsu_valid_i(lsu_valid),
    .lsu_ready_o(lsu_ready),
    .lsu_addr_i(lsu_addr),
    .lsu_data_i(lsu_data),
    .gpr_wr_en_o(gpr_wr_en),
    .gpr_wr_addr_o(gpr_wr_addr),
    .gpr_wr_data_o(gpr_wr_data),
    .hz1_addr_i(hz1_addr),
    .hz2_addr_i(hz2_addr),
    .hz1_o(hz1),
    .hz2_o(hz2),
    .ex_starved_o(ex_starved)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [AW+XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic ev, input logic [AW-1:0] ea,
                       input logic [XLEN-1:0] ed, input logic lv, input logic [AW-1:0] la,
                       input logic [XLEN-1:0] ld, input logic [AW-1:0] h1,
                       input logic [AW-1:0] h2);
    @(negedge clk);
    rst       = r;
    ex_valid  = ev;
    ex_addr   = ea;
    ex_data   = ed;
    lsu_valid = lv;
    lsu_addr  = la;
    lsu_data  = ld;
    hz1_addr  = h1;
    hz2_addr  = h2;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst, ev;
    logic [AW-1:0]   ea;
    logic [XLEN-1:0] ed;
    logic            lv;
    logic [AW-1:0]   la;
    logic [XLEN-1:0] ld;
    logic [AW-1:0]   h1, h2;
    logic            exr, lsr, st, ehz1, ehz2, en;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic ev, input logic [AW-1:0] ea,
                              input logic [XLEN-1:0] ed, input logic lv,
                              input logic [AW-1:0] la, input logic [XLEN-1:0] ld,
                              input logic [AW-1:0] h1, input logic [AW-1:0] h2,
                              input logic exr, input logic lsr, input logic st,
                              input logic ehz1, input logic ehz2, input logic en,
                              input logic [AW-1:0] waddr, input logic [XLEN-1:0] wdata);
    vec_t v;
    v.rst = r;   v.ev = ev;   v.ea = ea;   v.ed = ed;
    v.lv = lv;   v.la = la;   v.ld = ld;   v.h1 = h1;  v.h2 = h2;
    v.exr = exr; v.lsr = lsr; v.st = st;   v.ehz1 = ehz1; v.ehz2 = ehz2;
    v.en = en;   v.waddr = waddr; v.wdata = wdata;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  int              m_wait;   // consecutive cycles EX has been refused
  logic            m_en;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  logic            g_ex, g_lsu;

  // LSU wins conflicts unless EX has already waited SL cycles.
  task automatic model_grant();
    g_ex  = 1'b0;
    g_lsu = 1'b0;
    if (!rst) begin
      if (ex_valid && lsu_valid) begin
        if (m_wait >= SL) g_ex = 1'b1;
        else              g_lsu = 1'b1;
      end else begin
        g_ex  = ex_valid;
        g_lsu = lsu_valid;
      end
    end
  endtask

  function automatic logic model_hz(input logic [AW-1:0] h);
    logic [AW-1:0] busy[$];
    if (rst || h == '0) return 1'b0;
    if (ex_valid)  busy.push_back(ex_addr);
    if (lsu_valid) busy.push_back(lsu_addr);
    if (m_en)      busy.push_back(m_addr);
    foreach (busy[i]) if (busy[i] == h) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check();
    logic [AW+XLEN-1:0] e;
    model_grant();
    check("m_ex_ready",  64'(ex_ready),   64'(g_ex));
    check("m_lsu_ready", 64'(lsu_ready),  64'(g_lsu));
    check("m_starved",   64'(ex_starved), 64'(!rst && m_wait >= SL));
    check("m_hz1",       64'(hz1),        64'(model_hz(hz1_addr)));
    check("m_hz2",       64'(hz2),        64'(model_hz(hz2_addr)));
    check("m_wr_en",     64'(gpr_wr_en),  64'(m_en && !rst));
    if (m_en && !rst) begin
      check("m_wr_addr", 64'(gpr_wr_addr), 64'(m_addr));
      check("m_wr_data", 64'(gpr_wr_data), 64'(m_data));
    end
    if (gpr_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_write_order", 64'({gpr_wr_addr, gpr_wr_data}), 64'(e));
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_wait = 0;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      exp_q.delete();
    end else begin
      m_en = 1'b0;
      if (g_ex) begin
        m_en = (ex_addr != '0); m_addr = ex_addr; m_data = ex_data;
      end else if (g_lsu) begin
        m_en = (lsu_addr != '0); m_addr = lsu_addr; m_data = lsu_data;
      end
      if (m_en) exp_q.push_back({m_addr, m_data});
      if (ex_valid && !g_ex) m_wait = (m_wait + 1 > SL) ? SL : m_wait + 1;
      else                   m_wait = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  logic            r_ev, r_lv, r_rst;
  logic [AW-1:0]   r_ea, r_la, r_h1, r_h2;
  logic [XLEN-1:0] r_ed, r_ld;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_addr = '0; ex_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0; hz1_addr = '0; hz2_addr = '0;
    m_wait = 0; m_en = 1'b0; m_addr = '0; m_data = '0; g_ex = 1'b0; g_lsu = 1'b0;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_ex_ready",  64'(ex_ready),  64'(0));
    check("rst_lsu_ready", 64'(lsu_ready), 64'(0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_wr_en",   64'(gpr_wr_en),   64'(0));
    check("rst_wr_addr", 64'(gpr_wr_addr), 64'(0));
    check("rst_wr_data", 64'(gpr_wr_data), 64'(0));
    check("rst_starved", 64'(ex_starved), 64'(0));

    //  rst ev ea ed            lv la ld        h1 h2   exr lsr st hz1 hz2 en waddr wdata
    add(1, 0, 0, 0,            0, 0, 0,        0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // EX alone: ready same cycle, write next cycle, idle after
    add(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,        5, 0,   1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,            0, 0, 0,        5, 6,   0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF);
    add(0, 0, 0, 0,            0, 0, 0,        5, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // Conflict: LSU first, EX next, writes 7 then 3
    add(0, 1, 3, 32'h33,       1, 7, 32'h11,   3, 7,   0, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 3, 32'h33,       0, 0, 0,        7, 3,   1, 0, 0, 1, 1, 1, 7, 32'h11);
    add(0, 0, 0, 0,            0, 0, 0,        0, 0,   0, 0, 0, 0, 0, 1, 3, 32'h33);
    add(0, 0, 0, 0,            0, 0, 0,        3, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // Starvation: LSU streams, EX blocked 4 cycles then forced through
    add(0, 1, 10, 32'hA0,      1, 1, 32'h100,  10, 1,  0, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 10, 32'hA0,      1, 2, 32'h200,  1, 2,   0, 1, 0, 1, 1, 1, 1, 32'h100);
    add(0, 1, 10, 32'hA0,      1, 3, 32'h300,  0, 0,   0, 1, 0, 0, 0, 1, 2, 32'h200);
    add(0, 1, 10, 32'hA0,      1, 4, 32'h400,  0, 0,   0, 1, 0, 0, 0, 1, 3, 32'h300);
    add(0, 1, 10, 32'hA0,      1, 5, 32'h500,  4, 0,   1, 0, 1, 1, 0, 1, 4, 32'h400);
    add(0, 1, 11, 32'hB0,      1, 5, 32'h500,  0, 0,   0, 1, 0, 0, 0, 1, 10, 32'hA0);
    add(0, 1, 11, 32'hB0,      0, 0, 0,        0, 0,   1, 0, 0, 0, 0, 1, 5, 32'h500);
    add(0, 0, 0, 0,            0, 0, 0,        0, 0,   0, 0, 0, 0, 0, 1, 11, 32'hB0);
    add(0, 0, 0, 0,            0, 0, 0,        0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // x0 write: handshake completes, no GPR write, no hazard on x0
    add(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,        0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,            0, 0, 0,        0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // Hazard follows a write from request through registered cycle
    add(0, 0, 0, 0,            1, 9, 32'h99,   9, 0,   0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,            0, 0, 0,        9, 0,   0, 0, 0, 1, 0, 1, 9, 32'h99);
    add(0, 0, 0, 0,            0, 0, 0,        9, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // Reset right after a transfer discards the in-flight write
    add(0, 1, 12, 32'hC,       0, 0, 0,        12, 0,  1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 13, 32'hD,       1, 14, 32'hE,   12, 14, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,            0, 0, 0,        12, 0,  0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].lv,
            vecs[i].la, vecs[i].ld, vecs[i].h1, vecs[i].h2);
      check($sformatf("v%0d_ex_ready", i),  64'(ex_ready),   64'(vecs[i].exr));
      check($sformatf("v%0d_lsu_ready", i), 64'(lsu_ready),  64'(vecs[i].lsr));
      check($sformatf("v%0d_starved", i),   64'(ex_starved), 64'(vecs[i].st));
      check($sformatf("v%0d_hz1", i),       64'(hz1),        64'(vecs[i].ehz1));
      check($sformatf("v%0d_hz2", i),       64'(hz2),        64'(vecs[i].ehz2));
      check($sformatf("v%0d_wr_en", i),     64'(gpr_wr_en),  64'(vecs[i].en));
      if (vecs[i].en) begin
        check($sformatf("v%0d_wr_addr", i), 64'(gpr_wr_addr), 64'(vecs[i].waddr));
        check($sformatf("v%0d_wr_data", i), 64'(gpr_wr_data), 64'(vecs[i].wdata));
      end
    end
    // Registers cleared by the reset that discarded the x12 write
    check("post_rst_wr_addr", 64'(gpr_wr_addr), 64'(0));
    check("post_rst_wr_data", 64'(gpr_wr_data), 64'(0));

    // Randomized traffic against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_check();
    model_step();
    r_ev = 1'b0; r_lv = 1'b0; r_ea = '0; r_la = '0; r_ed = '0; r_ld = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!(r_ev && !g_ex)) begin
        r_ev = ($urandom_range(0, 3) != 0);
        r_ea = AW'($urandom_range(0, 31));
        r_ed = $urandom;
      end
      if (!(r_lv && !g_lsu)) begin
        r_lv = ($urandom_range(0, 7) != 0);
        r_la = AW'($urandom_range(0, 31));
        r_ld = $urandom;
      end
      r_rst = ($urandom_range(0, 99) == 0);
      r_h1  = ($urandom_range(0, 2) == 0) ? r_ea : AW'($urandom_range(0, 31));
      r_h2  = ($urandom_range(0, 2) == 0) ? r_la : AW'($urandom_range(0, 31));
      drive(r_rst, r_ev, r_ea, r_ed, r_lv, r_la, r_ld, r_h1, r_h2);
      model_check();
      model_step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_check();
      model_step();
    end
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
